// File: rtl/mb128_host.sv
`timescale 1ns/1ps
// mb128_host: host-side initiator for the MB128 serial save-memory protocol.
// Optional build macro MB128_HOST_IDENT_CHECK_EN aborts when i_Ident is not 1 at the A1/A2 samples.
module mb128_host #(
  parameter int LO_CYCLES = 76,
  parameter int HI_CYCLES = 175
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [9:0]  cmd_addr,
  input  logic [2:0]  cmd_bitlen,
  input  logic [16:0] cmd_bytelen,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  output logic        o_Clk,
  output logic        o_Data,
  input  logic        i_Data,
  input  logic        i_Ident,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SYNC, S_A1, S_A2, S_REQ, S_ADDR,
    S_LENBITS, S_LENBYTES, S_XFER_BYTE, S_XFER_BITS, S_TRAIL
  } state_t;

  localparam int TMAX = (LO_CYCLES > HI_CYCLES) ? LO_CYCLES : HI_CYCLES;
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] LO_LAST = TW'(LO_CYCLES - 1);
  localparam logic [TW-1:0] HI_LAST = TW'(HI_CYCLES - 1);
  localparam logic [7:0] SYNC_PAT = 8'hA8;

  state_t        state_q, state_d;
  logic          hi_q;
  logic [TW-1:0] timer_q;
  logic [4:0]    bit_idx_q;
  logic [16:0]   byte_left_q;
  logic          write_q;
  logic [9:0]    addr_q;
  logic [2:0]    bitlen_q;
  logic [16:0]   bytelen_q;
  logic [7:0]    wr_byte_q;
  logic          have_wr_q;
  logic [7:0]    rd_acc_q;

  logic [4:0]  field_len;
  logic [16:0] field_val;
  logic        tx_bit, last_bit, bit_end, need_wr, ident_ok, abort, finish;
  logic [7:0]  rd_next;

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign bit_end   = hi_q && (timer_q == HI_LAST);
  // A write byte is fetched at bit 0 of each byte and once at the start of the trailing bits.
  assign need_wr   = write_q && !have_wr_q && (bit_idx_q == 5'd0) &&
                     (state_q == S_XFER_BYTE || state_q == S_XFER_BITS);
  assign wr_ready  = need_wr;
  assign rd_next   = rd_acc_q | (8'(i_Data) << bit_idx_q[2:0]);
  assign tx_bit    = field_val[bit_idx_q];
  assign last_bit  = (bit_idx_q == field_len - 5'd1);

`ifdef MB128_HOST_IDENT_CHECK_EN
  logic ident_a1_q;
  assign ident_ok = ident_a1_q & i_Ident;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                            ident_a1_q <= 1'b0;
    else if (bit_end && state_q == S_A1) ident_a1_q <= i_Ident;
  end
`else
  logic unused_ident;
  assign unused_ident = i_Ident;
  assign ident_ok = 1'b1;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    field_len = 5'd1;
    field_val = '0;
    case (state_q)
      S_SYNC:      begin field_len = 5'd8;  field_val = {9'd0, SYNC_PAT}; end
      S_A2:        field_val = 17'd1;
      S_REQ:       field_val = {16'd0, ~write_q};
      S_ADDR:      begin field_len = 5'd10; field_val = {7'd0, addr_q}; end
      S_LENBITS:   begin field_len = 5'd3;  field_val = {14'd0, bitlen_q}; end
      S_LENBYTES:  begin field_len = 5'd17; field_val = bytelen_q; end
      S_XFER_BYTE: begin field_len = 5'd8;  field_val = write_q ? {9'd0, wr_byte_q} : '0; end
      S_XFER_BITS: begin field_len = {2'd0, bitlen_q}; field_val = write_q ? {9'd0, wr_byte_q} : '0; end
      S_TRAIL:     field_len = write_q ? 5'd5 : 5'd3;
      default:     ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    finish  = 1'b0;
    if (state_q == S_IDLE) begin
      if (cmd_valid) state_d = S_PRE;
    end else if (bit_end && last_bit) begin
      case (state_q)
        S_PRE:       state_d = S_SYNC;
        S_SYNC:      state_d = S_A1;
        S_A1:        state_d = S_A2;
        S_A2:        begin
                       state_d = ident_ok ? S_REQ : S_IDLE;
                       abort   = !ident_ok;
                     end
        S_REQ:       state_d = S_ADDR;
        S_ADDR:      state_d = S_LENBITS;
        S_LENBITS:   state_d = S_LENBYTES;
        S_LENBYTES:  state_d = (bytelen_q != '0) ? S_XFER_BYTE :
                               (bitlen_q != '0) ? S_XFER_BITS : S_TRAIL;
        S_XFER_BYTE: if (byte_left_q == 17'd1)
                       state_d = (bitlen_q != '0) ? S_XFER_BITS : S_TRAIL;
        S_XFER_BITS: state_d = S_TRAIL;
        default:     begin state_d = S_IDLE; finish = 1'b1; end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hi_q <= 1'b0;  timer_q <= '0;  bit_idx_q <= '0;  byte_left_q <= '0;
      write_q <= 1'b0;  addr_q <= '0;  bitlen_q <= '0;  bytelen_q <= '0;
      wr_byte_q <= '0;  have_wr_q <= 1'b0;  rd_acc_q <= '0;
      o_Clk <= 1'b0;  o_Data <= 1'b0;  rd_data <= '0;  rd_valid <= 1'b0;
      rd_last <= 1'b0;  done <= 1'b0;  error <= 1'b0;
    end else begin
      done     <= 1'b0;
      error    <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      if (state_q == S_IDLE) begin
        o_Clk <= 1'b0;  o_Data <= 1'b0;  hi_q <= 1'b0;  timer_q <= '0;
        bit_idx_q <= '0;  have_wr_q <= 1'b0;  rd_acc_q <= '0;
        if (cmd_valid) begin
          write_q     <= cmd_write;
          addr_q      <= cmd_addr;
          bitlen_q    <= cmd_bitlen;
          bytelen_q   <= cmd_bytelen;
          byte_left_q <= cmd_bytelen;
        end
      end else if (!hi_q) begin
        // While stalled for a write byte the timer holds at 0, so the LOW count restarts after it.
        if (need_wr) begin
          if (wr_valid) begin
            wr_byte_q <= wr_data;
            have_wr_q <= 1'b1;
          end
        end else begin
          if (timer_q == '0) o_Data <= tx_bit;
          if (timer_q == LO_LAST) begin
            hi_q    <= 1'b1;
            o_Clk   <= 1'b1;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
      end else if (!bit_end) begin
        timer_q <= timer_q + 1'b1;
      end else begin
        hi_q      <= 1'b0;
        o_Clk     <= 1'b0;
        timer_q   <= '0;
        bit_idx_q <= last_bit ? 5'd0 : bit_idx_q + 5'd1;
        if (!write_q && (state_q == S_XFER_BYTE || state_q == S_XFER_BITS)) begin
          if (last_bit) begin
            rd_data  <= rd_next;
            rd_valid <= 1'b1;
            rd_last  <= (state_q == S_XFER_BITS) ||
                        (byte_left_q == 17'd1 && bitlen_q == 3'd0);
            rd_acc_q <= '0;
          end else begin
            rd_acc_q <= rd_next;
          end
        end
        if (state_q == S_XFER_BYTE && last_bit) begin
          byte_left_q <= byte_left_q - 17'd1;
          have_wr_q   <= 1'b0;
        end
        if (abort || finish) begin
          o_Data <= 1'b0;
          done   <= finish;
          error  <= abort;
        end
      end
    end
  end

endmodule

// File: tb/tb_mb128_host.sv
`timescale 1ns/1ps
// tb_mb128_host: directed self-checking bench with a bit-level MB128 device model on o_Clk edges.
module tb_mb128_host;

  localparam int LO = 5;
  localparam int HI = 7;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [9:0]  cmd_addr = '0;
  logic [2:0]  cmd_bitlen = '0;
  logic [16:0] cmd_bytelen = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        i_Data = 1'b0;
  logic        i_Ident = 1'b1;
  logic        cmd_ready, wr_ready, rd_valid, rd_last, o_Clk, o_Data, busy, done, error;
  logic [7:0]  rd_data;

  mb128_host #(.LO_CYCLES(LO), .HI_CYCLES(HI)) dut (
    .clk_sys(clk_sys), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_bitlen(cmd_bitlen),
    .cmd_bytelen(cmd_bytelen), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .o_Clk(o_Clk), .o_Data(o_Data), .i_Data(i_Data), .i_Ident(i_Ident),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  int   rise_cnt = 0;
  int   base = 0;
  int   exp_len = 0;
  logic cap [128];
  logic dev_bits [128];
  logic exp_bits [128];
  logic [7:0] xbytes [4];

  logic [7:0] rd_dat [64];
  logic       rd_lst [64];
  int rd_cnt = 0, done_cnt = 0, err_cnt = 0;
  int rd0, done0, err0;
  int hold_bad, clk_bad, drop_bad, feed_to;

  // Device model: records host bit and presents its own bit for the period that just went high.
  always @(posedge o_Clk) begin : dev_model
    int idx;
    idx = rise_cnt - base;
    if (idx >= 0 && idx < 128) begin
      cap[idx] = o_Data;
      i_Data   = dev_bits[idx];
    end
    rise_cnt++;
  end

  always @(negedge clk_sys) begin
    if (rd_valid) begin
      if (rd_cnt < 64) begin
        rd_dat[rd_cnt] = rd_data;
        rd_lst[rd_cnt] = rd_last;
      end
      rd_cnt++;
    end
    if (done)  done_cnt++;
    if (error) err_cnt++;
  end

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      exp_bits[exp_len] = v[i];
      dev_bits[exp_len] = 1'b0;
      exp_len++;
    end
  endtask

  task automatic push_data(input logic [7:0] v, input int n, input bit wr);
    for (int i = 0; i < n; i++) begin
      exp_bits[exp_len] = wr ? v[i] : 1'b0;
      dev_bits[exp_len] = wr ? 1'b0 : v[i];
      exp_len++;
    end
  endtask

  task automatic build_exp(input bit wr, input logic [9:0] a, input logic [2:0] bl,
                           input logic [16:0] byl);
    exp_len = 0;
    for (int i = 0; i < 128; i++) begin
      exp_bits[i] = 1'b0;
      dev_bits[i] = 1'b0;
    end
    push_bits(32'h0, 1);
    push_bits(32'hA8, 8);
    push_bits(32'h0, 1);
    push_bits(32'h1, 1);
    push_bits(wr ? 32'h0 : 32'h1, 1);
    push_bits({22'd0, a}, 10);
    push_bits({29'd0, bl}, 3);
    push_bits({15'd0, byl}, 17);
    for (int k = 0; k < int'(byl); k++) push_data(xbytes[k], 8, wr);
    push_data(xbytes[int'(byl)], int'(bl), wr);
    push_bits(32'h0, wr ? 5 : 3);
  endtask

  task automatic stream_bad(output int bad);
    bad = 0;
    for (int i = 0; i < exp_len; i++)
      if (cap[i] !== exp_bits[i]) bad++;
  endtask

  task automatic start_cmd(input bit wr, input logic [9:0] a, input logic [2:0] bl,
                           input logic [16:0] byl);
    @(negedge clk_sys);
    #1;
    base  = rise_cnt;
    rd0   = rd_cnt;
    done0 = done_cnt;
    err0  = err_cnt;
    cmd_write = wr;  cmd_addr = a;  cmd_bitlen = bl;  cmd_bytelen = byl;
    cmd_valid = 1'b1;
    @(negedge clk_sys);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_sys);
      #2;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic feed(input int n, input int delay_idx, input int delay);
    bit seen;
    hold_bad = 0;  clk_bad = 0;  drop_bad = 0;  feed_to = 0;
    for (int k = 0; k < n; k++) begin
      seen = 1'b0;
      for (int w = 0; w < 1000; w++) begin
        if (wr_ready) begin
          seen = 1'b1;
          break;
        end
        @(posedge clk_sys);
        #2;
      end
      if (!seen) begin
        feed_to++;
        return;
      end
      if (k == delay_idx) begin
        for (int d = 0; d < delay; d++) begin
          @(posedge clk_sys);
          #2;
          if (!wr_ready) hold_bad++;
          if (o_Clk)     clk_bad++;
        end
      end
      wr_data  = xbytes[k];
      wr_valid = 1'b1;
      @(posedge clk_sys);
      #2;
      wr_valid = 1'b0;
      if (wr_ready) drop_bad++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    #2;
    checks++;
    if ({o_Clk, o_Data, busy, done, error, rd_valid, rd_last, wr_ready, cmd_ready} !== 9'b000000001) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=%b",
               {o_Clk, o_Data, busy, done, error, rd_valid, rd_last, wr_ready, cmd_ready}, 9'b000000001);
    end
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rd_data got=%h want=00", rd_data);
    end
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(posedge clk_sys);
    #2;
    checks++;
    if ({busy, cmd_ready, o_Clk} !== 3'b010) begin
      errors++;
      $display("FAIL post_reset_idle got=%b want=010", {busy, cmd_ready, o_Clk});
    end
  endtask

  task automatic check_read_result(input string tag, input bit ok);
    int bad;
    logic [7:0] want [3];
    want[0] = 8'h62;  want[1] = 8'hC3;  want[2] = 8'h01;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_done got=timeout want=done", tag);
    end
    checks++;
    if (rise_cnt - base != 63) begin
      errors++;
      $display("FAIL %s_periods got=%0d want=63", tag, rise_cnt - base);
    end
    stream_bad(bad);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_stream got=%0d bad bits want=0", tag, bad);
    end
    checks++;
    if (rd_cnt - rd0 != 3) begin
      errors++;
      $display("FAIL %s_strobes got=%0d want=3", tag, rd_cnt - rd0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd_dat[rd0 + k] !== want[k] || rd_lst[rd0 + k] !== (k == 2)) begin
          errors++;
          $display("FAIL %s_rd%0d got=%h/%b want=%h/%b", tag, k,
                   rd_dat[rd0 + k], rd_lst[rd0 + k], want[k], k == 2);
        end
      end
    end
  endtask

  task automatic test_read;
    bit ok;
    xbytes[0] = 8'h62;  xbytes[1] = 8'hC3;  xbytes[2] = 8'h01;  xbytes[3] = 8'h00;
    build_exp(1'b0, 10'h0A5, 3'd2, 17'd2);
    start_cmd(1'b0, 10'h0A5, 3'd2, 17'd2);
    repeat (30) @(posedge clk_sys);
    #2;
    checks++;
    if ({busy, cmd_ready} !== 2'b10) begin
      errors++;
      $display("FAIL read_busy got=%b want=10", {busy, cmd_ready});
    end
    cmd_write = 1'b1;  cmd_bytelen = 17'd0;  cmd_bitlen = 3'd0;  cmd_valid = 1'b1;
    @(posedge clk_sys);
    #2;
    cmd_valid = 1'b0;
    wait_done(2000, ok);
    check_read_result("read", ok);
    checks++;
    if ({o_Clk, o_Data, cmd_ready, busy} !== 4'b0010) begin
      errors++;
      $display("FAIL read_end_idle got=%b want=0010", {o_Clk, o_Data, cmd_ready, busy});
    end
    checks++;
    if (err_cnt != err0) begin
      errors++;
      $display("FAIL read_error_pulse got=%0d want=0", err_cnt - err0);
    end
  endtask

  task automatic run_write(input string tag, input int delay_idx, input int delay);
    bit ok;
    int bad;
    xbytes[0] = 8'h62;  xbytes[1] = 8'hC3;  xbytes[2] = 8'h01;  xbytes[3] = 8'h00;
    build_exp(1'b1, 10'h0A5, 3'd2, 17'd2);
    start_cmd(1'b1, 10'h0A5, 3'd2, 17'd2);
    fork
      feed(3, delay_idx, delay);
      wait_done(4000, ok);
    join
    checks++;
    if (!ok || feed_to != 0) begin
      errors++;
      $display("FAIL %s_done got=ok%0d/timeouts%0d want=ok1/timeouts0", tag, ok, feed_to);
    end
    checks++;
    if (rise_cnt - base != 65) begin
      errors++;
      $display("FAIL %s_periods got=%0d want=65", tag, rise_cnt - base);
    end
    stream_bad(bad);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_stream got=%0d bad bits want=0", tag, bad);
    end
    checks++;
    if (drop_bad != 0 || rd_cnt != rd0) begin
      errors++;
      $display("FAIL %s_handshake got=drop%0d/rd%0d want=0/0", tag, drop_bad, rd_cnt - rd0);
    end
  endtask

  task automatic test_write;
    run_write("write", -1, 0);
  endtask

  task automatic test_write_stall;
    run_write("stall", 1, 1000);
    checks++;
    if (hold_bad != 0 || clk_bad != 0) begin
      errors++;
      $display("FAIL stall_hold got=ready_low%0d/clk_high%0d want=0/0", hold_bad, clk_bad);
    end
  endtask

  task automatic test_zero_len;
    bit ok;
    int bad;
    xbytes[0] = 8'h00;
    build_exp(1'b0, 10'h3FF, 3'd0, 17'd0);
    start_cmd(1'b0, 10'h3FF, 3'd0, 17'd0);
    wait_done(2000, ok);
    checks++;
    if (!ok || rise_cnt - base != 45) begin
      errors++;
      $display("FAIL zero_periods got=ok%0d/%0d want=ok1/45", ok, rise_cnt - base);
    end
    checks++;
    if (rd_cnt != rd0) begin
      errors++;
      $display("FAIL zero_no_rd got=%0d want=0", rd_cnt - rd0);
    end
    stream_bad(bad);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL zero_stream got=%0d bad bits want=0", bad);
    end
  endtask

  task automatic test_reset_mid_addr;
    bit ok, reached;
    xbytes[0] = 8'h62;  xbytes[1] = 8'hC3;  xbytes[2] = 8'h01;
    build_exp(1'b0, 10'h0A5, 3'd2, 17'd2);
    start_cmd(1'b0, 10'h0A5, 3'd2, 17'd2);
    reached = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk_sys);
      #2;
      if (rise_cnt - base >= 15 && o_Clk) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL rst_reach_addr got=%0d periods want>=15", rise_cnt - base);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({o_Clk, o_Data, busy, done, error, rd_valid, rd_last, wr_ready, cmd_ready} !== 9'b000000001) begin
      errors++;
      $display("FAIL rst_mid_outputs got=%b want=%b",
               {o_Clk, o_Data, busy, done, error, rd_valid, rd_last, wr_ready, cmd_ready}, 9'b000000001);
    end
    @(negedge clk_sys);
    reset = 1'b0;
    start_cmd(1'b0, 10'h0A5, 3'd2, 17'd2);
    wait_done(2000, ok);
    check_read_result("rst_rerun", ok);
  endtask

`ifdef MB128_HOST_IDENT_CHECK_EN
  task automatic test_ident;
    bit seen;
    i_Ident = 1'b0;
    build_exp(1'b0, 10'h0A5, 3'd2, 17'd2);
    start_cmd(1'b0, 10'h0A5, 3'd2, 17'd2);
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk_sys);
      #2;
      if (error) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || rise_cnt - base != 11) begin
      errors++;
      $display("FAIL ident_abort got=seen%0d/%0d want=seen1/11", seen, rise_cnt - base);
    end
    checks++;
    if ({cmd_ready, o_Clk, o_Data} !== 3'b100 || done_cnt != done0 || rd_cnt != rd0) begin
      errors++;
      $display("FAIL ident_idle got=%b/done%0d/rd%0d want=100/0/0",
               {cmd_ready, o_Clk, o_Data}, done_cnt - done0, rd_cnt - rd0);
    end
    i_Ident = 1'b1;
  endtask
`endif

  initial begin
    test_reset;
    test_read;
    test_write;
    test_write_stall;
    test_zero_len;
    test_reset_mid_addr;
`ifdef MB128_HOST_IDENT_CHECK_EN
    test_ident;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
